// File: rtl/display_scanner_if.sv
// Display scanner bus: scan controls in, digit/anode drive out.
//   en          - scanning enable
//   digit_mask  - bit i set => digit i takes part in the scan
//   digit       - index of the digit owning the current slot
//   anode_n     - one-hot, active-low anode drive
//   blank       - high while no anode is driven
//   frame_start - one-cycle pulse at the start of each scan frame
interface display_scanner_if #(
  parameter int N_DIGITS = 4
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;

  logic                en;
  logic [N_DIGITS-1:0] digit_mask;
  logic [IDX_W-1:0]    digit;
  logic [N_DIGITS-1:0] anode_n;
  logic                blank;
  logic                frame_start;

  modport master (output en, digit_mask, input digit, anode_n, blank, frame_start);
  modport slave  (input en, digit_mask, output digit, anode_n, blank, frame_start);
endinterface

// File: rtl/display_scanner.sv
// Multiplexed display scanner. Each enabled digit owns a slot of
// TICKS_PER_DIGIT cycles. The first GUARD cycles of a slot are blank to avoid
// ghosting, and the anode is driven for the rest of the slot. Digits absent
// from digit_mask are skipped.
// Ports:
//   clk   - clock, rising edge
//   reset - asynchronous, active-low reset
//   bus   - display_scanner_if slave (en, digit_mask in; digit, anode_n,
//           blank, frame_start out, all registered)
module display_scanner #(
  parameter int N_DIGITS        = 4,
  parameter int TICKS_PER_DIGIT = 500000,
  parameter int GUARD           = 1000
) (
  input  logic              clk,
  input  logic              reset,
  display_scanner_if.slave  bus
);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int TW    = $clog2(TICKS_PER_DIGIT);
  localparam logic [TW-1:0]       T_LAST = TW'(TICKS_PER_DIGIT - 1);
  localparam logic [TW-1:0]       G_LAST = TW'(GUARD - 1);
  localparam logic [N_DIGITS-1:0] ONE    = N_DIGITS'(1);

  typedef enum logic [1:0] {ST_OFF, ST_GUARD, ST_DRIVE} state_t;

  state_t              state_q, state_d;
  logic [TW-1:0]       timer_q, timer_d;
  logic [IDX_W-1:0]    digit_q, digit_d;
  logic [N_DIGITS-1:0] an_q, an_d;
  logic                blank_q, blank_d;
  logic                fs_q, fs_d;
  // Latches a mid-slot mask drop so the rest of the slot stays dark.
  logic                kill_q, kill_d;

  // Lowest set mask bit, and the lowest set bit strictly above digit_q.
  logic [IDX_W-1:0] first_idx, next_idx;
  logic             first_ok, next_ok;

  always_comb begin
    first_idx = '0;
    first_ok  = 1'b0;
    next_idx  = '0;
    next_ok   = 1'b0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      if (bus.digit_mask[i]) begin
        first_idx = IDX_W'(i);
        first_ok  = 1'b1;
        if (i > int'(digit_q)) begin
          next_idx = IDX_W'(i);
          next_ok  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    digit_d = digit_q;
    kill_d  = kill_q;
    an_d    = '1;
    blank_d = 1'b1;
    fs_d    = 1'b0;
    if (!bus.en) begin
      state_d = ST_OFF;
      timer_d = '0;
      kill_d  = 1'b0;
    end else begin
      case (state_q)
        ST_OFF: begin
          timer_d = '0;
          if (first_ok) begin
            state_d = ST_GUARD;
            digit_d = first_idx;
            fs_d    = 1'b1;
            kill_d  = 1'b0;
          end
        end
        default: begin
          if (timer_q == T_LAST) begin
            // Slot advance: the mask is sampled here only.
            timer_d = '0;
            kill_d  = 1'b0;
            if (!first_ok) begin
              state_d = ST_OFF;
            end else begin
              state_d = ST_GUARD;
              digit_d = next_ok ? next_idx : first_idx;
              // No higher bit means the frame wrapped (incl. single-bit mask).
              fs_d    = !next_ok;
            end
          end else begin
            timer_d = timer_q + 1'b1;
            if (state_q == ST_GUARD && timer_q == G_LAST) state_d = ST_DRIVE;
            if (state_d == ST_DRIVE) begin
              if (kill_q || !bus.digit_mask[digit_q]) begin
                kill_d = 1'b1;
              end else begin
                an_d    = ~(ONE << digit_q);
                blank_d = 1'b0;
              end
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_OFF;
      timer_q <= '0;
      digit_q <= '0;
      an_q    <= '1;
      blank_q <= 1'b1;
      fs_q    <= 1'b0;
      kill_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      digit_q <= digit_d;
      an_q    <= an_d;
      blank_q <= blank_d;
      fs_q    <= fs_d;
      kill_q  <= kill_d;
    end
  end

  assign bus.digit       = digit_q;
  assign bus.anode_n     = an_q;
  assign bus.blank       = blank_q;
  assign bus.frame_start = fs_q;
endmodule

// File: tb/tb_display_scanner.sv
// Directed bench for display_scanner with N_DIGITS=4, TICKS_PER_DIGIT=8,
// GUARD=2. Cycle c is the state observed 1 time unit after the c-th edge of
// a phase.
module tb_display_scanner;
  localparam int N = 4;
  localparam int T = 8;
  localparam int G = 2;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  display_scanner_if #(.N_DIGITS(N)) bus();

  display_scanner #(.N_DIGITS(N), .TICKS_PER_DIGIT(T), .GUARD(G)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s got=%0h want=%0h", tag, obs, exp);
    end
  endtask

  function automatic int drv(input int d);
    return 15 & ~(1 << d);
  endfunction

  task automatic exp_all(input string tag, input int d, input int an, input int fs);
    chk({tag, ".digit"}, int'(bus.digit), d);
    chk({tag, ".anode"}, int'(bus.anode_n), an);
    chk({tag, ".blank"}, int'(bus.blank), (an == 15) ? 1 : 0);
    chk({tag, ".fs"},    int'(bus.frame_start), fs);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int d;
    bus.en         = 1'b0;
    bus.digit_mask = 4'b0000;
    #2 reset = 1'b0;
    repeat (2) tick();
    exp_all("rst", 0, 15, 0);

    // Full mask: digits 0..3, frame pulse only at start and at the wrap.
    bus.en         = 1'b1;
    bus.digit_mask = 4'b1111;
    reset          = 1'b1;
    for (int c = 0; c < 40; c++) begin
      tick();
      d = (c / 8) % 4;
      exp_all($sformatf("A%0d", c), d, (c % 8 >= G) ? drv(d) : 15,
              (c == 0 || c == 32) ? 1 : 0);
    end

    // Sparse mask 1010: 1,3,1,3; wrap back to 1 pulses frame_start.
    bus.digit_mask = 4'b1010;
    for (int c = 0; c < 32; c++) begin
      tick();
      d = ((c / 8) % 2 == 1) ? 3 : 1;
      exp_all($sformatf("B%0d", c), d, (c % 8 >= G) ? drv(d) : 15,
              (c == 16) ? 1 : 0);
    end

    // Single-bit mask: digit 2 advances to itself, pulse every slot.
    bus.digit_mask = 4'b0100;
    for (int c = 0; c < 24; c++) begin
      tick();
      exp_all($sformatf("C%0d", c), 2, (c % 8 >= G) ? drv(2) : 15,
              (c % 8 == 0) ? 1 : 0);
    end

    // Mask bit of the live digit (3) dropped at slot cycle 4.
    bus.digit_mask = 4'b1111;
    for (int c = 0; c < 5; c++) begin
      tick();
      exp_all($sformatf("D%0d", c), 3, (c >= G) ? drv(3) : 15, 0);
    end
    bus.digit_mask = 4'b0111;
    for (int c = 5; c < 30; c++) begin
      tick();
      d = (c < 8) ? 3 : (c - 8) / 8;
      exp_all($sformatf("D%0d", c), d, (c >= 8 && c % 8 >= G) ? drv(d) : 15,
              (c == 8) ? 1 : 0);
    end

    // Disable at slot cycle 5 of digit 2, then re-enable.
    bus.en = 1'b0;
    tick(); exp_all("off0", 2, 15, 0);
    tick(); exp_all("off1", 2, 15, 0);
    bus.en = 1'b1;
    tick(); exp_all("re0", 0, 15, 1);
    tick(); exp_all("re1", 0, 15, 0);
    tick(); exp_all("re2", 0, drv(0), 0);

    // Asynchronous reset in the middle of digit 1's drive window.
    repeat (9) tick();
    exp_all("pre_rst", 1, drv(1), 0);
    #2 reset = 1'b0;
    #1 exp_all("async_rst", 0, 15, 0);
    tick();
    reset = 1'b1;
    tick(); exp_all("rel0", 0, 15, 1);
    tick(); exp_all("rel1", 0, 15, 0);
    tick(); exp_all("rel2", 0, drv(0), 0);

    // Empty mask at an advance: scanner parks in OFF, digit held.
    repeat (13) tick();
    exp_all("pre_off", 1, drv(1), 0);
    bus.digit_mask = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      tick();
      exp_all($sformatf("E%0d", c), 1, 15, 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
